// File: rtl/display_scan_if.sv
// Display scan interface: groups the button/blank inputs and the display
// outputs of display_scan_ctrl.
//   i_mode_btn   raw mode push-button (async, active-high)
//   i_blank      synchronous force-all-anodes-off
//   o_digit_sel  digit mux select 0..3
//   o_an         anode enables, active-low
//   o_switch     mux mode select bit
//   o_switch2    mux mode select bit
//   o_mode       00 TIME, 01 DATE, 10 ALARM
//   o_frame_tick one-cycle pulse on digit_sel wrap 3->0
interface display_scan_if;
  logic       i_mode_btn;
  logic       i_blank;
  logic [1:0] o_digit_sel;
  logic [3:0] o_an;
  logic       o_switch;
  logic       o_switch2;
  logic [1:0] o_mode;
  logic       o_frame_tick;

  modport slave (
    input  i_mode_btn, i_blank,
    output o_digit_sel, o_an, o_switch, o_switch2, o_mode, o_frame_tick
  );

  modport master (
    output i_mode_btn, i_blank,
    input  o_digit_sel, o_an, o_switch, o_switch2, o_mode, o_frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Wristwatch 7-segment scan sequencer: digit-scan index, guarded active-low
// anode enables, debounced mode button and TIME/DATE/ALARM mode FSM.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    display_scan_if.slave (button/blank in, display controls out)
//
// state      | meaning
// -----------+---------------------------------------------
// MODE_TIME  | time shown, switch=1 switch2=0, no timeout
// MODE_DATE  | date shown, switch=0 switch2=0, timeout runs
// MODE_ALARM | alarm shown, switch=1 switch2=1, timeout runs
module display_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 64,
  parameter int DEB_CYCLES     = 500000,
  parameter int TIMEOUT_FRAMES = 2500
) (
  input  logic          clk,
  input  logic          rst_n,
  display_scan_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_V  = CNT_W'(GUARD);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_FRAMES - 1);

  localparam logic [1:0] MODE_TIME  = 2'b00;
  localparam logic [1:0] MODE_DATE  = 2'b01;
  localparam logic [1:0] MODE_ALARM = 2'b10;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_digit_sel;
  logic [3:0]       r_an;
  logic             r_frame_tick;
  logic             r_mode_blank;
  logic             r_sync1, r_sync2;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic             r_deb;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [1:0]       r_mode;
  logic             r_switch, r_switch2;

  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_digit_nxt;
  logic             w_mode_blank_nxt;
  logic [3:0]       w_an_nxt;
  logic             w_diff, w_deb_take, w_press;
  logic             w_tmo_hit;
  logic [1:0]       w_mode_nxt;
  logic             w_switch_nxt, w_switch2_nxt;

  // Scan prescaler and digit index
  assign w_wrap      = (r_cnt == CNT_LAST);
  assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_digit_nxt = w_wrap ? r_digit_sel + 2'd1 : r_digit_sel;

  // A mode change blanks the rest of the slot it lands in; a change on the
  // wrap edge blanks the whole new slot.
  assign w_mode_blank_nxt = (w_mode_nxt != r_mode) | (r_mode_blank & ~w_wrap);

  // Anodes are computed from next-state values so the registered output
  // lines up with the cnt/digit_sel of the same cycle.
  assign w_an_nxt = ((w_cnt_nxt >= GUARD_V) && !bus.i_blank && !w_mode_blank_nxt)
                    ? ~(4'b0001 << w_digit_nxt) : 4'b1111;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_digit_sel  <= 2'd0;
      r_frame_tick <= 1'b0;
      r_mode_blank <= 1'b0;
      r_an         <= 4'b1111;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_digit_sel  <= w_digit_nxt;
      r_frame_tick <= w_wrap && (r_digit_sel == 2'd3);
      r_mode_blank <= w_mode_blank_nxt;
      r_an         <= w_an_nxt;
    end
  end

  // Button path. r_fill marks when r_sync2 holds a real sample; r_armed is set
  // only once the button has actually been seen low, so a button held through
  // reset does not produce a press when it is finally debounced high.
  assign w_diff     = r_sync2 ^ r_deb;
  assign w_deb_take = w_diff && (r_deb_cnt == DEB_LAST);
  assign w_press    = w_deb_take && r_sync2 && r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_fill    <= 2'b00;
      r_armed   <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bus.i_mode_btn;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync2) r_armed <= 1'b1;
      if (!w_diff) begin
        r_deb_cnt <= '0;
      end else if (w_deb_take) begin
        r_deb_cnt <= '0;
        r_deb     <= r_sync2;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
    end
  end

  // Timeout: counts frames outside TIME; press clears it and wins over a hit.
  assign w_tmo_hit = ((r_mode == MODE_DATE) || (r_mode == MODE_ALARM)) &&
                     r_frame_tick && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_press || (r_mode == MODE_TIME) || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else if (r_frame_tick) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Mode FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= MODE_TIME;
      r_switch  <= 1'b1;
      r_switch2 <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_switch  <= w_switch_nxt;
      r_switch2 <= w_switch2_nxt;
    end
  end

  // Mode FSM: next state
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      MODE_TIME:  if (w_press) w_mode_nxt = MODE_DATE;
      MODE_DATE:  if (w_press) w_mode_nxt = MODE_ALARM;
                  else if (w_tmo_hit) w_mode_nxt = MODE_TIME;
      MODE_ALARM: if (w_press || w_tmo_hit) w_mode_nxt = MODE_TIME;
      default:    w_mode_nxt = MODE_TIME;
    endcase
  end

  // Mode FSM: output decode, registered together with the mode
  always_comb begin
    w_switch_nxt  = 1'b1;
    w_switch2_nxt = 1'b0;
    case (w_mode_nxt)
      MODE_DATE:  begin w_switch_nxt = 1'b0; w_switch2_nxt = 1'b0; end
      MODE_ALARM: begin w_switch_nxt = 1'b1; w_switch2_nxt = 1'b1; end
      default:    begin w_switch_nxt = 1'b1; w_switch2_nxt = 1'b0; end
    endcase
  end

  assign bus.o_digit_sel  = r_digit_sel;
  assign bus.o_an         = r_an;
  assign bus.o_switch     = r_switch;
  assign bus.o_switch2    = r_switch2;
  assign bus.o_mode       = r_mode;
  assign bus.o_frame_tick = r_frame_tick;

endmodule
